// File: rtl/mul_div_pkg.sv
//------------------------------------------------------------------------------
// Module   : mul_div_pkg
// Purpose  : Shared types and helpers for the mul_div block set.
//            Contains the IDLE/RUN/DONE control-state encoding and the
//            iteration-counter width helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mul_div_pkg;

  // Control states shared by the iterative multiply and divide units
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed for a counter that must hold the values 0..width
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : mul_div_pkg

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
//------------------------------------------------------------------------------
// Module   : shift_add_multiplier
// Purpose  : Sequential unsigned shift-and-add multiplier. Captures A and B
//            on an accepted start, adds one partial product per clock and
//            strobes done for one cycle when the product is registered.
// Options  : SHIFT_ADD_MUL_EARLY_TERM_EN - finish as soon as no set bits
//            remain in the shifted multiplier (product unchanged, only
//            done timing differs).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_add_multiplier
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = count_width(WIDTH);

  state_t             r_state;
  state_t             w_state_next;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;

  logic               w_accept;
  logic               w_last;
  logic [2*WIDTH-1:0] w_sum;
  logic [WIDTH-1:0]   w_mplier_shift;

  // start is only honoured when no operation is in flight
  assign w_accept       = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Partial-product step; 2*WIDTH bits always hold (2^WIDTH-1)^2
  assign w_sum          = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_shift = r_mplier >> 1;

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  // Stop once the counter expires or no multiplier bits are left to add
  assign w_last = (r_count == CW'(1)) || (w_mplier_shift == '0);
`else
  // Always run the full WIDTH iterations
  assign w_last = (r_count == CW'(1));
`endif

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; DONE can relaunch directly for back-to-back operation
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, one iteration per RUN cycle, product load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand   <= {{WIDTH{1'b0}}, multiplicand};
      r_mplier  <= multiplier;
      r_acc     <= '0;
      r_count   <= CW'(WIDTH);
    end else if (r_state == ST_RUN) begin
      r_acc     <= w_sum;
      r_mcand   <= r_mcand << 1;
      r_mplier  <= w_mplier_shift;
      r_count   <= r_count - CW'(1);
      if (w_last) begin
        r_product <= w_sum;
      end
    end
  end

  assign product = r_product;
  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);

endmodule : shift_add_multiplier

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
//------------------------------------------------------------------------------
// Module   : tb_shift_add_multiplier
// Purpose  : Self-checking bench for shift_add_multiplier (WIDTH=4).
//            Expected products and latencies come from plain arithmetic.
//            Honours SHIFT_ADD_MUL_EARLY_TERM_EN for the latency model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_add_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Reference: cycles from the start edge until done is visible
  function automatic int model_latency(input int b);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    if (b == 0) return 1;
    for (int i = W - 1; i >= 0; i--) begin
      if (((b >> i) & 1) == 1) return i + 1;
    end
    return 1;
`else
    return W;
`endif
  endfunction

  // Stimulus: launch one operation and count edges until done (-1 on timeout)
  task automatic run_op(input int a, input int b, output int lat);
    multiplicand = a[W-1:0];
    multiplier   = b[W-1:0];
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    lat          = -1;
    for (int i = 1; i <= W + 3; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (product !== '0) begin
      errors++;
      $display("FAIL reset_product got=%0d want=0", product);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%b done=%b want busy=0 done=0", busy, done);
    end
  endtask

  task automatic test_directed();
    int as [3] = '{13, 15, 9};
    int bs [3] = '{3, 15, 0};
    int lat;
    for (int k = 0; k < 3; k++) begin
      run_op(as[k], bs[k], lat);
      checks++;
      if (lat !== model_latency(bs[k])) begin
        errors++;
        $display("FAIL dir_latency a=%0d b=%0d got=%0d want=%0d", as[k], bs[k], lat, model_latency(bs[k]));
      end
      checks++;
      if (product !== 8'(as[k] * bs[k])) begin
        errors++;
        $display("FAIL dir_product a=%0d b=%0d got=%0d want=%0d", as[k], bs[k], product, as[k] * bs[k]);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL dir_busy_with_done got=%b want=0", busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL dir_done_width got=%b want=0", done);
      end
    end
  endtask

  task automatic test_random();
    int a, b, lat;
    for (int k = 0; k < 24; k++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(0, (1 << W) - 1));
      run_op(a, b, lat);
      checks++;
      if (lat !== model_latency(b) || product !== 8'(a * b)) begin
        errors++;
        $display("FAIL rand_op a=%0d b=%0d got prod=%0d lat=%0d want prod=%0d lat=%0d",
                 a, b, product, lat, a * b, model_latency(b));
      end
      // idle gap of random length between operations
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_start_during_run();
    int a, b, ndone, lat, prod_at_done;
    a = int'($urandom_range(1, (1 << W) - 1));
    b = int'($urandom_range(1 << (W - 1), (1 << W) - 1));
    multiplicand = a[W-1:0];
    multiplier   = b[W-1:0];
    start        = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL sdr_busy_after_start got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    // second request while running, with different operands
    multiplicand = W'(a ^ 5);
    multiplier   = W'(b ^ 6);
    ndone = 0;
    lat = -1;
    prod_at_done = -1;
    for (int i = 1; i <= W + 4; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          prod_at_done = int'(product);
        end
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL sdr_done_count got=%0d want=1", ndone);
    end
    checks++;
    if (prod_at_done !== a * b || lat !== model_latency(b)) begin
      errors++;
      $display("FAIL sdr_result got prod=%0d lat=%0d want prod=%0d lat=%0d",
               prod_at_done, lat, a * b, model_latency(b));
    end
  endtask

  task automatic test_mid_reset();
    int ndone;
    multiplicand = 4'd15;
    multiplier   = 4'd15;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (product !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got prod=%0d busy=%b done=%b want 0 0 0", product, busy, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0 || product !== '0) begin
      errors++;
      $display("FAIL midrst_quiet got active_cycles=%0d prod=%0d want 0 0", ndone, product);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    run_op(13, 3, lat1);
    checks++;
    if (product !== 8'd39 || lat1 !== model_latency(3)) begin
      errors++;
      $display("FAIL b2b_first got prod=%0d lat=%0d want prod=39 lat=%0d", product, lat1, model_latency(3));
    end
    // still inside the DONE cycle: relaunch immediately
    run_op(7, 5, lat2);
    checks++;
    if (product !== 8'd35) begin
      errors++;
      $display("FAIL b2b_second_product got=%0d want=35", product);
    end
    checks++;
    if (lat2 + 1 !== model_latency(5) + 1 || lat2 < 0) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d want=%0d", lat2 + 1, model_latency(5) + 1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_return_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_run();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_add_multiplier

`default_nettype wire

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned shift-and-add multiplier for the `mul_div` block set; the multiplication counterpart of the restoring divider. It shares that block's handshake shape: a `start` pulse, an iterative datapath with one partial product per clock, and a one-cycle `done` strobe. It sits beside the divider as the iterative multiply unit for small-width datapaths.

## Interface
- `WIDTH`, default 4: operand width in bits; product is 2*WIDTH.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `multiplicand`  in  WIDTH  unsigned operand A; captured on an accepted start.
- `multiplier`  in  WIDTH  unsigned operand B; captured on an accepted start.
- `product`  out  2*WIDTH  registered A*B; holds its value until the next completion.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle strobe in the cycle after the final iteration.

One clock; reset is asynchronous and active-high (`clk`, `rst`).

## Operation
- Internal registers: `mcand` (2*WIDTH), `mplier` (WIDTH), `acc` (2*WIDTH), `count` (clog2(WIDTH+1) bits).
- States:
  - IDLE: outputs quiescent.
  - RUN: one iteration per clock.
  - DONE: `done`=1 for exactly one cycle.
- Transitions:
  - IDLE to RUN on `start`.
  - RUN to DONE after the last iteration.
  - DONE to RUN on `start`, which allows back-to-back operations.
  - DONE to IDLE otherwise.
- Load, on an accepted start:
  - `mcand` = zero-extended A.
  - `mplier` = B.
  - `acc` = 0.
  - `count` = WIDTH.
- RUN iteration:
  - if `mplier[0]`, then `acc` += `mcand`.
  - `mcand` <<= 1.
  - `mplier` >>= 1.
  - `count` -= 1.
- Last iteration: the one where `count` goes to 0. On that edge, `product` is loaded with the final accumulated value (the value including this iteration's add).
- Width rules: the addition is 2*WIDTH bits and cannot overflow, because the maximum result is (2^WIDTH-1)^2. No saturation and no signed handling.
- `start` in RUN is ignored. It is not queued, and the operands are not re-captured.
- Operands may change freely after the capture edge.
- Reset, including mid-operation:
  - state goes to IDLE.
  - `product`=0, `busy`=0, `done`=0.
  - `acc`, `mcand`, `mplier` and `count` are cleared.
  - The in-flight operation is lost and no `done` is issued.

## Timing
- Reset values: `product`=0, `busy`=0, `done`=0, state IDLE.
- Start is sampled at edge 0. `busy` is high from after edge 0 until the edge where RUN is left.
- Latency without early termination: iterations occur at edges 1..WIDTH. `done` and the new `product` are visible after edge WIDTH, and `done` drops at edge WIDTH+1.
- Back-to-back: if `start` is asserted during the DONE cycle, the next load happens at edge WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- `busy` and `done` are never high together.

## Configuration
- `SHIFT_ADD_MUL_EARLY_TERM_EN` defined:
  - RUN also ends at the first iteration whose shifted `mplier` is zero, i.e. when no set bits remain.
  - Latency = (index of B's highest set bit)+1 iterations.
  - B=0 completes after 1 iteration, with `product`=0.
- Not defined: every operation takes exactly WIDTH iterations.
- The `product` value is identical in both builds. Only `done` timing differs.

## Structure
- Shared package `mul_div_pkg`:
  - FSM state enum (IDLE/RUN/DONE), shared with the divider's control style.
  - Count-width helper constant/function.
- No sub-module: datapath and FSM live inline.

## Test plan
- WIDTH=4, rst pulse, then A=13, B=3, start for one cycle -> `product`=8'd39, `done` high for exactly one cycle, 4 cycles after the start edge (early-term build: 2 cycles).
- A=15, B=15 -> `product`=8'd225, latency 4 in both builds.
- A=9, B=0 -> `product`=0; latency 4 without the macro, 1 with it.
- Start pulse again in the cycle after a start, while `busy` is high -> ignored, `product` = result of the first operands only, a single `done`.
- Assert `rst` for one cycle in the middle of RUN -> `product`=0, `busy`=0, and no `done` until a new start.
- A=13, B=3 followed by A=7, B=5 with `start` held in the DONE cycle -> `product` 39, then 35, with `done` strobes WIDTH+1 cycles apart.
